// File: rtl/sap_ctrl_seq.sv
// ============================================================================
// Module   : sap_ctrl_seq
// Brief    : Ring-counter controller-sequencer for the 8-bit accumulator
//            datapath; decodes T-state and opcode into bus/load strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sap_ctrl_seq #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] tstate
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t r_tstate;
  tstate_t w_tstate_next;
  logic    r_halt;
  logic    w_active;
  logic    w_halt_edge;

  // Strobes only drive the datapath when the ring is actually allowed to move.
  assign w_active    = run & ~r_halt & ~clr;
  assign w_halt_edge = (r_tstate == T4) && (opcode == OP_HLT);

  // Any non-legal encoding falls back to T1 so the ring self-recovers.
  always_comb begin
    w_tstate_next = T1;
    case (r_tstate)
      T1:      w_tstate_next = T2;
      T2:      w_tstate_next = T3;
      T3:      w_tstate_next = T4;
      T4:      w_tstate_next = T5;
      T5:      w_tstate_next = T6;
      T6:      w_tstate_next = T1;
      default: w_tstate_next = T1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_tstate <= T1;
      r_halt   <= 1'b0;
    end else if (run && !r_halt) begin
      if (w_halt_edge) begin
        r_halt <= 1'b1;
      end else begin
        r_tstate <= w_tstate_next;
      end
    end
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    if (w_active) begin
      case (r_tstate)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: begin
          cp = 1'b1;
        end
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        default: begin
          cp = 1'b0;
        end
      endcase
    end
  end

  assign hlt    = r_halt;
  assign tstate = r_tstate;

endmodule

`default_nettype wire

// File: tb/tb_sap_ctrl_seq.sv
// ============================================================================
// Module   : tb_sap_ctrl_seq
// Brief    : Directed scoreboard bench for the sap_ctrl_seq sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sap_ctrl_seq;

  localparam logic [11:0] C_CP = 12'h800;
  localparam logic [11:0] C_EP = 12'h400;
  localparam logic [11:0] C_LM = 12'h200;
  localparam logic [11:0] C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080;
  localparam logic [11:0] C_EI = 12'h040;
  localparam logic [11:0] C_LA = 12'h020;
  localparam logic [11:0] C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EU = 12'h004;
  localparam logic [11:0] C_LB = 12'h002;
  localparam logic [11:0] C_LO = 12'h001;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  typedef struct packed {
    logic [5:0]  t;
    logic [11:0] c;
    logic        h;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       run;
  logic [3:0] opcode;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [5:0] tstate;
  logic [11:0] ctrl;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  assign ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  sap_ctrl_seq dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .opcode (opcode),
    .cp     (cp),
    .ep     (ep),
    .lm     (lm),
    .ce     (ce),
    .li     (li),
    .ei     (ei),
    .la     (la),
    .ea     (ea),
    .su     (su),
    .eu     (eu),
    .lb     (lb),
    .lo     (lo),
    .hlt    (hlt),
    .tstate (tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus drivers must never collide and the ring must stay one-hot.
  always @(negedge clk) begin
    checks++;
    assert ($countones({ep, ce, ei, ea, eu}) <= 1) else begin
      failures++;
      $error("FAIL bus_excl observed=%b expected=at_most_one", {ep, ce, ei, ea, eu});
    end
    checks++;
    assert ($countones(tstate) == 1) else begin
      failures++;
      $error("FAIL onehot observed=%b expected=one_bit_set", tstate);
    end
  end

  task automatic compare_pop(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (tstate === e.t) else begin
      failures++;
      $error("FAIL %s.tstate observed=%b expected=%b", tag, tstate, e.t);
    end
    checks++;
    assert (ctrl === e.c) else begin
      failures++;
      $error("FAIL %s.ctrl observed=%h expected=%h", tag, ctrl, e.c);
    end
    checks++;
    assert (hlt === e.h) else begin
      failures++;
      $error("FAIL %s.hlt observed=%b expected=%b", tag, hlt, e.h);
    end
  endtask

  // One clock cycle: expectation queued, checked mid-cycle, then advance.
  task automatic step(input string tag, input logic [5:0] t, input logic [11:0] c, input logic h);
    sb_q.push_back('{t: t, c: c, h: h});
    @(negedge clk);
    compare_pop(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [5:0] t, input logic [11:0] c, input logic h);
    sb_q.push_back('{t: t, c: c, h: h});
    compare_pop(tag);
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t1"}, S1, C_EP | C_LM, 1'b0);
    step({tag, "_t2"}, S2, C_CP, 1'b0);
    step({tag, "_t3"}, S3, C_CE | C_LI, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr    = 1'b1;
    run    = 1'b0;
    opcode = 4'b0000;
    step("rst0", S1, 12'h000, 1'b0);
    run = 1'b1;
    step("rst1", S1, 12'h000, 1'b0);
    clr = 1'b0;

    // LDA
    fetch("lda");
    step("lda_t4", S4, C_EI | C_LM, 1'b0);
    step("lda_t5", S5, C_CE | C_LA, 1'b0);
    step("lda_t6", S6, 12'h000, 1'b0);

    // ADD
    opcode = 4'b0001;
    fetch("add");
    step("add_t4", S4, C_EI | C_LM, 1'b0);
    step("add_t5", S5, C_CE | C_LB, 1'b0);
    step("add_t6", S6, C_EU | C_LA, 1'b0);

    // SUB
    opcode = 4'b0010;
    fetch("sub");
    step("sub_t4", S4, C_EI | C_LM, 1'b0);
    step("sub_t5", S5, C_CE | C_LB, 1'b0);
    step("sub_t6", S6, C_SU | C_EU | C_LA, 1'b0);

    // OUT
    opcode = 4'b1110;
    fetch("out");
    step("out_t4", S4, C_EA | C_LO, 1'b0);
    step("out_t5", S5, 12'h000, 1'b0);
    step("out_t6", S6, 12'h000, 1'b0);

    // Undefined opcode runs as NOP and the ring still wraps
    opcode = 4'b0111;
    fetch("nop");
    step("nop_t4", S4, 12'h000, 1'b0);
    step("nop_t5", S5, 12'h000, 1'b0);
    step("nop_t6", S6, 12'h000, 1'b0);

    // Pause in T2
    opcode = 4'b0000;
    step("pz_t1", S1, C_EP | C_LM, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 5; i++) step("pz_hold", S2, 12'h000, 1'b0);
    run = 1'b1;
    step("pz_t2", S2, C_CP, 1'b0);
    step("pz_t3", S3, C_CE | C_LI, 1'b0);
    step("pz_t4", S4, C_EI | C_LM, 1'b0);

    // Asynchronous clear between edges in T5 of LDA
    #2;
    check_now("ar_pre", S5, C_CE | C_LA, 1'b0);
    clr = 1'b1;
    #1;
    check_now("ar_clr", S1, 12'h000, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Halt, with a pause on the halting T4 edge first
    opcode = 4'b1111;
    fetch("hlt");
    run = 1'b0;
    step("hlt_pz0", S4, 12'h000, 1'b0);
    step("hlt_pz1", S4, 12'h000, 1'b0);
    run = 1'b1;
    step("hlt_t4", S4, 12'h000, 1'b0);
    opcode = 4'b0000;
    for (int i = 0; i < 20; i++) step("hlt_hold", S4, 12'h000, 1'b1);
    clr = 1'b1;
    #1;
    check_now("hlt_clr", S1, 12'h000, 1'b0);
    @(negedge clk);
    #1;
    clr = 1'b0;
    #1;
    check_now("hlt_rel", S1, C_EP | C_LM, 1'b0);
    @(posedge clk);
    #1;
    step("post_t2", S2, C_CP, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
